// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive front end.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

endpackage

// File: rtl/ps2_in_filter.sv
// Synchronizes the PS/2 lines, debounces the clock and emits a one-cycle
// pulse on each accepted falling edge of the filtered clock.
module ps2_in_filter #(
  parameter int FILTER = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_fall,
  output logic o_data
);

  localparam logic [3:0] FILT_LAST = 4'(FILTER - 1);

  logic       r_clk_s1;
  logic       r_clk_s2;
  logic       r_dat_s1;
  logic       r_dat_s2;
  logic       r_fclk;
  logic       r_fall;
  logic [3:0] r_cnt;

  // Lines idle high, so the synchronizers and filtered clock reset high to
  // avoid a phantom falling edge when reset is released.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_fclk   <= 1'b1;
      r_fall   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= 1'b0;
      if (r_clk_s2 != r_fclk) begin
        if (r_cnt == FILT_LAST) begin
          r_fclk <= r_clk_s2;
          r_cnt  <= '0;
          r_fall <= ~r_clk_s2;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_fall = r_fall;
  assign o_data = r_dat_s2;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix folding into key events.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a start bit (data 0 on fall)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing parity result against the running accumulator
// ST_STOP   | checking stop bit, then strobing byte or error
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout
);

  localparam logic [16:0] TO_LAST = 17'(TIMEOUT - 1);

  logic        w_fall;
  logic        w_data;
  logic        w_to_hit;

  ps2_state_t  r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_acc;
  logic        r_par_bad;
  logic [16:0] r_to_cnt;

  logic        r_byte_valid;
  logic [7:0]  r_byte_data;
  logic        r_parity_err;
  logic        r_frame_err;
  logic        r_timeout;

  logic        r_ext_f;
  logic        r_rel_f;
  logic        r_key_valid;
  logic [7:0]  r_key_code;
  logic        r_key_ext;
  logic        r_key_release;

  ps2_in_filter #(
    .FILTER (FILTER)
  ) u_filter (
    .i_clk      (clk_sys),
    .i_rst_n    (reset_n),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_fall     (w_fall),
    .o_data     (w_data)
  );

  assign w_to_hit = (r_state != ST_IDLE) && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_acc        <= 1'b0;
      r_par_bad    <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_timeout    <= 1'b0;

      if ((r_state == ST_IDLE) || w_fall) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 17'd1;
      end

      // A fall coinciding with the timeout is dropped along with the frame.
      if (w_to_hit) begin
        r_timeout <= 1'b1;
        r_state   <= ST_IDLE;
      end else if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_data) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
              r_acc     <= 1'b1;
            end
          end
          ST_DATA: begin
            r_shift <= {w_data, r_shift[7:1]};
            r_acc   <= r_acc ^ w_data;
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          ST_PARITY: begin
            r_par_bad <= r_acc ^ w_data;
            r_state   <= ST_STOP;
          end
          ST_STOP: begin
            if (!w_data) begin
              r_frame_err <= 1'b1;
            end else if (r_par_bad) begin
              r_parity_err <= 1'b1;
            end else begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= r_shift;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_ext_f       <= 1'b0;
      r_rel_f       <= 1'b0;
      r_key_valid   <= 1'b0;
      r_key_code    <= '0;
      r_key_ext     <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (r_byte_valid) begin
        if (r_byte_data == PS2_EXT) begin
          r_ext_f <= 1'b1;
        end else if (r_byte_data == PS2_REL) begin
          r_rel_f <= 1'b1;
        end else begin
          r_key_valid   <= 1'b1;
          r_key_code    <= r_byte_data;
          r_key_ext     <= r_ext_f;
          r_key_release <= r_rel_f;
          r_ext_f       <= 1'b0;
          r_rel_f       <= 1'b0;
        end
      end else if (r_parity_err || r_frame_err || r_timeout) begin
        r_ext_f <= 1'b0;
        r_rel_f <= 1'b0;
      end
    end
  end

  assign byte_valid  = r_byte_valid;
  assign byte_data   = r_byte_data;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign timeout     = r_timeout;
  assign key_valid   = r_key_valid;
  assign key_code    = r_key_code;
  assign key_ext     = r_key_ext;
  assign key_release = r_key_release;

endmodule
